// File: rtl/interval_timer_pkg.sv
// Shared types and helpers for the interval timer arbiter: FSM state encoding,
// tick-count derivation and the round-robin winner search.
package interval_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int C_MAX_REQ = 8;
  localparam int C_PICK_W  = 3;

  // Clock cycles per millisecond; the clock frequency is a multiple of 1000.
  function automatic int calc_tick_cycles(input int clk_frq);
    return clk_frq / 1000;
  endfunction

  // First set bit of req at or above ptr, wrapping at n; 0 when req is empty.
  function automatic logic [C_PICK_W-1:0] rr_pick(
    input logic [C_MAX_REQ-1:0] req,
    input logic [C_PICK_W-1:0]  ptr,
    input int                   n
  );
    logic [C_PICK_W-1:0] idx;
    logic                found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < C_MAX_REQ; i++) begin
      idx = C_PICK_W'((int'(ptr) + i) % n);
      if (!found && (i < n) && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/interval_timer_arbiter_if.sv
// Requester-side bundle of the shared interval timer plus FSM state for debug.
interface interval_timer_arbiter_if #(
  parameter int C_REQ       = 4,
  parameter int C_LEN_WIDTH = 8
);
  import interval_timer_pkg::*;

  // Level handshake: a requester raises req[i] with len field i valid and holds
  // it until done[i] pulses or it aborts by dropping req[i]; gnt[i] is high
  // exactly while its interval runs, len is only sampled on the granting edge.
  logic [C_REQ-1:0]             req;
  logic [C_REQ*C_LEN_WIDTH-1:0] len;
  logic [C_REQ-1:0]             gnt;
  logic [C_REQ-1:0]             done;
  logic                         busy;
  state_t                       dbg_state;

  modport master (
    output req, len,
    input  gnt, done, busy, dbg_state
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, dbg_state
  );

endinterface

// File: rtl/ms_tick.sv
// Millisecond prescaler: one-cycle tick every C_TICK_CYCLES enabled cycles.
module ms_tick #(
  parameter int C_TICK_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int C_CNT_W = (C_TICK_CYCLES > 1) ? $clog2(C_TICK_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_TICK_CYCLES - 1);

  logic [C_CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Shared millisecond interval timer: round-robin grants one requester at a
// time, counts its interval in ms ticks and pulses done on completion.
module interval_timer_arbiter
  import interval_timer_pkg::*;
#(
  parameter int C_CLK_FRQ   = 100_000_000,
  parameter int C_REQ       = 4,
  parameter int C_LEN_WIDTH = 8
) (
  input logic                     clk,
  input logic                     rstb,
  interval_timer_arbiter_if.slave bus
);

  localparam int C_TICK_CYCLES = calc_tick_cycles(C_CLK_FRQ);
  localparam int C_IDX_W       = $clog2(C_REQ);

  state_t                 state_q, state_d;
  logic [C_IDX_W-1:0]     winner_q, winner_d;
  logic [C_IDX_W-1:0]     ptr_q, ptr_d;
  logic [C_IDX_W-1:0]     pick_idx, next_ptr;
  logic [C_LEN_WIDTH-1:0] ms_q, ms_d, pick_len;
  logic [C_REQ-1:0]       gnt_q, gnt_d;
  logic [C_REQ-1:0]       done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   tick_clr, tick_en, tick;

  function automatic logic [C_REQ-1:0] onehot(input logic [C_IDX_W-1:0] idx);
    return C_REQ'(1) << idx;
  endfunction

  ms_tick #(
    .C_TICK_CYCLES(C_TICK_CYCLES)
  ) u_ms_tick (
    .clk  (clk),
    .rstb (rstb),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    pick_idx = C_IDX_W'(rr_pick(C_MAX_REQ'(bus.req), C_PICK_W'(ptr_q), C_REQ));
    pick_len = C_LEN_WIDTH'(bus.len >> (pick_idx * C_LEN_WIDTH));
    next_ptr = (winner_q == C_IDX_W'(C_REQ - 1)) ? '0 : winner_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    ms_d     = ms_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    tick_clr = 1'b0;
    tick_en  = 1'b0;

    case (state_q)
      IDLE: begin
        tick_clr = 1'b1;
        if (|bus.req) begin
          winner_d = pick_idx;
          ms_d     = pick_len;
          busy_d   = 1'b1;
          // A zero-length request completes without ever being granted.
          if (pick_len == '0) begin
            state_d = DONE;
            done_d  = onehot(pick_idx);
          end else begin
            state_d = RUN;
            gnt_d   = onehot(pick_idx);
          end
        end
      end

      RUN: begin
        tick_en = 1'b1;
        // Abort wins over a coinciding last tick: no done for a dropped request.
        if (!bus.req[winner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
        end else if (tick) begin
          ms_d = ms_q - 1'b1;
          if (ms_q == C_LEN_WIDTH'(1)) begin
            state_d = DONE;
            gnt_d   = '0;
            done_d  = onehot(winner_q);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = next_ptr;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      ms_q     <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      ms_q     <= ms_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Bench for interval_timer_arbiter: directed scenarios plus random traffic,
// every cycle checked against a cycle-countdown reference model.
module tb_interval_timer_arbiter;
  import interval_timer_pkg::*;

  localparam int N       = 4;
  localparam int LW      = 8;
  localparam int LEN_W   = N * LW;
  localparam int CLK_FRQ = 10_000;
  localparam int TC      = 10;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  interval_timer_arbiter_if #(.C_REQ(N), .C_LEN_WIDTH(LW)) bus ();

  interval_timer_arbiter #(
    .C_CLK_FRQ   (CLK_FRQ),
    .C_REQ       (N),
    .C_LEN_WIDTH (LW)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Owner counts down its whole interval in clock cycles (len * TC).
  int m_owner  = -1;
  int m_left   = 0;
  int m_done_w = -1;
  int m_ptr    = 0;
  int m_w      = 0;
  int m_l      = 0;

  function automatic int pick_first(input logic [N-1:0] r, input int p);
    logic [1:0] idx;
    for (int i = 0; i < N; i++) begin
      idx = 2'((p + i) % N);
      if (r[idx]) return int'(idx);
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_owner = -1; m_left = 0; m_done_w = -1; m_ptr = 0;
    end else if (m_done_w >= 0) begin
      m_ptr    = (m_done_w + 1) % N;
      m_done_w = -1;
    end else if (m_owner >= 0) begin
      if (((bus.req >> m_owner) & N'(1)) == '0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done_w = m_owner;
          m_owner  = -1;
        end
      end
    end else if (bus.req != '0) begin
      m_w = pick_first(bus.req, m_ptr);
      m_l = int'(LW'(bus.len >> (m_w * LW)));
      if (m_l == 0) m_done_w = m_w;
      else begin
        m_owner = m_w;
        m_left  = m_l * TC;
      end
    end
  end

  logic [N-1:0] exp_gnt, exp_done;
  logic         exp_busy;
  always_comb begin
    exp_gnt  = '0;
    exp_done = '0;
    if (m_owner >= 0)  exp_gnt  = N'(1) << m_owner;
    if (m_done_w >= 0) exp_done = N'(1) << m_done_w;
    exp_busy = (m_owner >= 0) || (m_done_w >= 0);
  end

  // ---------------- driver tasks ----------------
  task automatic set_len(input int i, input int v);
    bus.len = (bus.len & ~(LEN_W'(8'hFF) << (i * LW))) | (LEN_W'(v[LW-1:0]) << (i * LW));
  endtask

  task automatic test_reset();
    rstb    = 1'b0;
    bus.req = '0;
    bus.len = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.done, bus.busy} !== '0 || bus.dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset: gnt=%b done=%b busy=%b state=%0d, want all 0 / IDLE",
               bus.gnt, bus.done, bus.busy, bus.dbg_state);
    end
    rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int g = 0, d = 0, b = 0, first = -1;
    set_len(0, 3);
    bus.req = 4'b0001;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.busy} !== {exp_gnt, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL single_model @%0t: got %b/%b/%b want %b/%b/%b", $time,
                 bus.gnt, bus.done, bus.busy, exp_gnt, exp_done, exp_busy);
      end
      if (bus.gnt == 4'b0001) begin g++; if (first < 0) first = c; end
      if (bus.done == 4'b0001) begin d++; bus.req = '0; end
      if (bus.busy) b++;
    end
    n_cmp++;
    if (g != 30 || d != 1 || b != 31 || first != 1) begin
      n_fail++;
      $display("FAIL single_len: gnt_cycles=%0d done=%0d busy=%0d first=%0d, want 30/1/31/1",
               g, d, b, first);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_q[$];
    logic [N-1:0] prev = '0;
    logic [1:0]   e;
    int gap = 0, ngr = 0, idx;
    @(negedge clk); rstb = 1'b0;
    @(negedge clk); rstb = 1'b1;
    for (int i = 0; i < N; i++) set_len(i, 1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    bus.req = 4'b1111;
    for (int c = 0; c < 200 && ngr < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.busy} !== {exp_gnt, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL rr_model @%0t: got %b/%b/%b want %b/%b/%b", $time,
                 bus.gnt, bus.done, bus.busy, exp_gnt, exp_done, exp_busy);
      end
      if (bus.gnt != '0 && prev == '0) begin
        idx = onehot_idx(bus.gnt);
        e   = exp_q.pop_front();
        n_cmp++;
        if (idx != int'(e) || (ngr > 0 && gap != 2)) begin
          n_fail++;
          $display("FAIL rr_order: grant %0d went to %0d after gap %0d, want %0d after gap 2",
                   ngr, idx, gap, e);
        end
        ngr++;
        gap = 0;
      end
      if (bus.gnt == '0) gap++;
      prev = bus.gnt;
    end
    n_cmp++;
    if (ngr != 5) begin
      n_fail++;
      $display("FAIL rr_timeout: saw %0d grants, want 5", ngr);
    end
    bus.req = '0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_zero_len();
    set_len(2, 0);
    bus.req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 4'b0100 || bus.gnt !== '0 || bus.busy !== 1'b1
        || {bus.gnt, bus.done, bus.busy} !== {exp_gnt, exp_done, exp_busy}) begin
      n_fail++;
      $display("FAIL zero_done: gnt=%b done=%b busy=%b, want 0000/0100/1", bus.gnt, bus.done, bus.busy);
    end
    bus.req = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== '0 || bus.busy !== 1'b0 || bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL zero_after: gnt=%b done=%b busy=%b, want 0000/0000/0", bus.gnt, bus.done, bus.busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    set_len(2, 5);
    bus.req = 4'b0100;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmid_run: gnt=%b, want 0100", bus.gnt);
    end
    #2 rstb = 1'b0;
    #1;
    n_cmp++;
    if ({bus.gnt, bus.done, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: gnt=%b done=%b busy=%b, want all 0", bus.gnt, bus.done, bus.busy);
    end
    @(negedge clk);
    set_len(0, 1); set_len(3, 1);
    bus.req = 4'b1001;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmid_ptr: gnt=%b, want 0001", bus.gnt);
    end
    for (int c = 0; c < 30 && seen == 0; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.busy} !== {exp_gnt, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL rmid_model @%0t: got %b/%b/%b want %b/%b/%b", $time,
                 bus.gnt, bus.done, bus.busy, exp_gnt, exp_done, exp_busy);
      end
      if (bus.done == 4'b0001) begin seen = 1; bus.req = '0; end
    end
    n_cmp++;
    if (seen == 0) begin
      n_fail++;
      $display("FAIL rmid_done: no done[0] within 30 cycles, want one");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    int cnt = 0, d1 = 0, d3 = 0;
    set_len(1, 5); set_len(3, 1);
    bus.req = 4'b1010;
    for (int c = 0; c < 40 && cnt < 17; c++) begin
      @(negedge clk);
      if (bus.gnt == 4'b0010) cnt++;
    end
    n_cmp++;
    if (cnt != 17) begin
      n_fail++;
      $display("FAIL abort_timeout: %0d grant cycles for req1, want 17", cnt);
    end
    bus.req = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.done !== '0) begin
      n_fail++;
      $display("FAIL abort_drop: gnt=%b done=%b busy=%b, want 0000/0000/0", bus.gnt, bus.done, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_next: gnt=%b, want 1000", bus.gnt);
    end
    for (int c = 0; c < 20 && d3 == 0; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.busy} !== {exp_gnt, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL abort_model @%0t: got %b/%b/%b want %b/%b/%b", $time,
                 bus.gnt, bus.done, bus.busy, exp_gnt, exp_done, exp_busy);
      end
      if (bus.done[1]) d1++;
      if (bus.done == 4'b1000) begin d3 = 1; bus.req = '0; end
    end
    n_cmp++;
    if (d1 != 0 || d3 != 1) begin
      n_fail++;
      $display("FAIL abort_done: done1=%0d done3=%0d, want 0/1", d1, d3);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_len_change();
    int g = 0, d = 0;
    set_len(0, 2);
    bus.req = 4'b0001;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.busy} !== {exp_gnt, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL lenchg_model @%0t: got %b/%b/%b want %b/%b/%b", $time,
                 bus.gnt, bus.done, bus.busy, exp_gnt, exp_done, exp_busy);
      end
      if (bus.gnt == 4'b0001) begin
        g++;
        if (g == 5) set_len(0, 9);
      end
      if (bus.done == 4'b0001) begin d++; bus.req = '0; end
    end
    n_cmp++;
    if (g != 20 || d != 1) begin
      n_fail++;
      $display("FAIL lenchg_len: gnt_cycles=%0d done=%0d, want 20/1", g, d);
    end
  endtask

  task automatic test_random();
    bus.req = '0;
    for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 3));
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.busy} !== {exp_gnt, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL random_model @%0t: got %b/%b/%b want %b/%b/%b", $time,
                 bus.gnt, bus.done, bus.busy, exp_gnt, exp_done, exp_busy);
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) bus.req = bus.req ^ (N'(1) << i);
        if ($urandom_range(0, 7) == 0) set_len(i, $urandom_range(0, 3));
      end
    end
    bus.req = '0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL random_idle: busy=%b gnt=%b, want 0/0000", bus.busy, bus.gnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_reset_mid();
    test_abort();
    test_len_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/interval_timer_arbiter.md
# interval_timer_arbiter

Shared millisecond interval timer for the sigma-delta ADC example: several requesters (debounce windows, LED blink phases, ADC settle waits) share one prescaler and one interval counter instead of each instantiating its own wide counter. Round-robin arbitration grants the timer to one requester at a time, times its requested interval, and signals completion. The block sits between the control logic and the board I/O helpers in the synthesis tree.

## Interface
- C_CLK_FRQ, 100_000_000, clock frequency [Hz]; must be a multiple of 1000.
- C_REQ, 4, number of requesters (2..8).
- C_LEN_WIDTH, 8, width of each interval length field [ms].
- clk  input  1  master clock.
- rstb  input  1  reset, asynchronous, active low.
- req  input  C_REQ  per-requester request level; held high until done or abort.
- len  input  C_REQ*C_LEN_WIDTH  interval length in ms; field i is bits [i*C_LEN_WIDTH +: C_LEN_WIDTH]; sampled at grant only.
- gnt  output  C_REQ  one-hot grant, high while the requester's interval runs.
- done  output  C_REQ  one-cycle completion pulse for the served requester.
- busy  output  1  high in any state other than IDLE.

## Operation
- Derived constant: C_TICK_CYCLES = C_CLK_FRQ / 1000, i.e. cycles per ms; prescaler width $clog2(C_TICK_CYCLES).
- States: IDLE, RUN, DONE.
- IDLE: if any req bit is high, the winner is the first set bit at or after pointer rPtr, scanning upward with wrap-around. Latch the winner index, load rMs <= len field of the winner, clear the prescaler, and go to RUN. If the latched length is 0, go to DONE instead; gnt never asserts.
- RUN: gnt[winner] = 1. The prescaler counts 0..C_TICK_CYCLES-1; on the terminal count it emits a tick and wraps. On each tick rMs decrements. A tick with rMs == 1 moves the FSM to DONE.
- DONE: lasts one cycle. done[winner] = 1 and gnt = 0. rPtr <= winner+1 mod C_REQ. Return to IDLE.
- Abort: if req[winner] is low in RUN, go to IDLE on the next edge. gnt drops, no done pulse is generated, and rPtr advances past the winner.
- If a requester keeps req high after its done pulse, that is a new request. It is arbitrated behind the other requesters by the round-robin pointer.
- req bits other than the winner's are ignored in RUN and DONE. len changes during RUN are ignored.
- Reset (asynchronous, any state): state=IDLE, rPtr=0, rMs=0, prescaler=0, gnt=0, done=0, busy=0. An interval in progress is discarded without a done pulse.

## Timing
- All outputs are registered.
- Request-to-grant: req rises while in IDLE at edge k, so gnt is high from edge k+1.
- Interval: gnt is high for exactly len*C_TICK_CYCLES cycles. done is high in the cycle after the last gnt cycle.
- Zero length: req at edge k gives done at edge k+1, for 1 cycle.
- Back-to-back service: done at cycle d, IDLE at d+1, next gnt at d+2. The minimum gap between grants is 2 cycles.
- busy is high from the first gnt/DONE cycle through the DONE cycle inclusive.
- Abort: req low sampled at edge a, so gnt is low from edge a+1 and busy is low at a+1.

## Structure
- Package interval_timer_pkg holds:
  - the state enumeration (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a C_TICK_CYCLES derivation function;
  - a round-robin first-set-bit-from-pointer function.
- Sub-module ms_tick is the prescaler.
  - Ports: clk, rstb, clr, en, tick.
  - tick is a one-cycle pulse every C_TICK_CYCLES enabled cycles, and clr restarts the count.
  - The arbiter FSM, pointer and rMs counter stay in the top module.

## Test plan
- Bench parameters: C_CLK_FRQ=10_000 (C_TICK_CYCLES=10), C_REQ=4, C_LEN_WIDTH=8.
- Single request: req=4'b0001 with len0=3 → gnt=4'b0001 for exactly 30 cycles, then done=4'b0001 for 1 cycle; busy high for 31 cycles.
- Round robin: req=4'b1111 held, all lengths 1, after reset → grant order 0,1,2,3,0, with a 2-cycle gap between grants.
- Zero length: req[2] with len2=0 → done[2] one cycle after the request; gnt stays 0.
- Abort: req[1] with len1=5, dropped after 17 grant cycles → gnt=0 on the next cycle, no done pulse; a pending req[3] is granted 1 cycle after IDLE is reached.
- Reset mid-interval: rstb low asynchronously during RUN → gnt, done and busy go to 0 immediately. After release, req[0] is granted first (pointer=0).
- len change during RUN: len0 changes from 2 to 9 mid-interval → the interval still ends after 20 cycles.
